// File: rtl/pong_frame_renderer_pkg.sv
// Shared geometry defaults, colours and flash-state encoding
// for the pipelined Pong frame renderer.
package pong_frame_renderer_pkg;

  localparam int DEF_SCREEN_WIDTH      = 640;
  localparam int DEF_SCREEN_HEIGHT     = 480;
  localparam int DEF_PADDLE_WIDTH      = 10;
  localparam int DEF_PADDLE_HEIGHT     = 60;
  localparam int DEF_PADDLE_INSET      = 20;
  localparam int DEF_BALL_SIZE         = 10;
  localparam int DEF_CENTER_LINE_WIDTH = 4;
  localparam int DEF_DASH_PERIOD       = 20;
  localparam int DEF_GLYPH_SCALE       = 8;
  localparam int DEF_FLASH_FRAMES      = 30;
  localparam int COLOR_W               = 4;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  localparam logic [COLOR_W-1:0] C_ON  = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] C_OFF = {COLOR_W{1'b0}};
  localparam logic [COLOR_W-1:0] C_MID = {1'b0, {(COLOR_W-1){1'b1}}};

  localparam rgb_t RED   = '{r: C_ON,  g: C_OFF, b: C_OFF};
  localparam rgb_t GREEN = '{r: C_OFF, g: C_ON,  b: C_OFF};
  localparam rgb_t WHITE = '{r: C_ON,  g: C_ON,  b: C_ON};
  localparam rgb_t GREY  = '{r: C_MID, g: C_MID, b: C_MID};
  localparam rgb_t BLACK = '{r: C_OFF, g: C_OFF, b: C_OFF};

  typedef enum logic {
    FL_IDLE  = 1'b0,
    FL_FLASH = 1'b1
  } flash_st_t;

  // Widened to 11 bits so lo+len never wraps past 1023.
  function automatic logic in_span(
    input logic [9:0]  v,
    input logic [9:0]  lo,
    input logic [10:0] len
  );
    logic [10:0] w_v;
    logic [10:0] w_lo;
    w_v  = {1'b0, v};
    w_lo = {1'b0, lo};
    return (w_v >= w_lo) && (w_v < w_lo + len);
  endfunction

endpackage

// File: rtl/pong_frame_renderer_score_glyph_rom.sv
// 3x5 digit font: one pixel per (digit, column, row).
// Codes 10-15 and out-of-cell addresses are blank.
module score_glyph_rom
  import pong_frame_renderer_pkg::*;
(
  input  logic [3:0] i_digit,
  input  logic [1:0] i_col,
  input  logic [2:0] i_row,
  output logic       o_pix
);

  logic [14:0] w_rows;
  logic [15:0] w_bits;
  logic [3:0]  w_idx;

  // Row 0 in the top three bits, column 0 is the MSB of each row.
  always_comb begin
    unique case (i_digit)
      4'd0:    w_rows = 15'b111_101_101_101_111;
      4'd1:    w_rows = 15'b010_110_010_010_111;
      4'd2:    w_rows = 15'b111_001_111_100_111;
      4'd3:    w_rows = 15'b111_001_111_001_111;
      4'd4:    w_rows = 15'b101_101_111_001_001;
      4'd5:    w_rows = 15'b111_100_111_001_111;
      4'd6:    w_rows = 15'b111_100_111_101_111;
      4'd7:    w_rows = 15'b111_001_001_001_001;
      4'd8:    w_rows = 15'b111_101_111_101_111;
      4'd9:    w_rows = 15'b111_101_111_001_111;
      default: w_rows = 15'b0;
    endcase
  end

  assign w_bits = {w_rows, 1'b0};
  assign w_idx  = ({1'b0, i_row} * 4'd3) + {2'b00, i_col};
  assign o_pix  = (i_col != 2'd3) && (i_row < 3'd5)
                  ? w_bits[4'd15 - w_idx] : 1'b0;

endmodule

// File: rtl/pong_frame_renderer.sv
// Two-stage Pong pixel renderer with per-frame shadow
// registers and flashing score digits after a goal.
module pong_frame_renderer
  import pong_frame_renderer_pkg::*;
#(
  parameter int SCREEN_WIDTH      = DEF_SCREEN_WIDTH,
  parameter int SCREEN_HEIGHT     = DEF_SCREEN_HEIGHT,
  parameter int PADDLE_WIDTH      = DEF_PADDLE_WIDTH,
  parameter int PADDLE_HEIGHT     = DEF_PADDLE_HEIGHT,
  parameter int PADDLE_INSET      = DEF_PADDLE_INSET,
  parameter int BALL_SIZE         = DEF_BALL_SIZE,
  parameter int CENTER_LINE_WIDTH = DEF_CENTER_LINE_WIDTH,
  parameter int DASH_PERIOD       = DEF_DASH_PERIOD,
  parameter int GLYPH_SCALE       = DEF_GLYPH_SCALE,
  parameter int FLASH_FRAMES      = DEF_FLASH_FRAMES
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_valid,
  input  logic               frame_start,
  input  logic [9:0]         x,
  input  logic [9:0]         y,
  input  logic [9:0]         paddle1_y,
  input  logic [9:0]         paddle2_y,
  input  logic [9:0]         ball_x,
  input  logic [9:0]         ball_y,
  input  logic [3:0]         score1,
  input  logic [3:0]         score2,
  input  logic               goal_p1,
  input  logic               goal_p2,
  output logic [COLOR_W-1:0] vga_red,
  output logic [COLOR_W-1:0] vga_green,
  output logic [COLOR_W-1:0] vga_blue,
  output logic               out_valid
);

  localparam int CLOG = $clog2(FLASH_FRAMES + 1);
  localparam int CW   = (CLOG < 3) ? 3 : CLOG;
  localparam int P2X  = SCREEN_WIDTH - PADDLE_INSET - PADDLE_WIDTH;
  localparam int LNX  = SCREEN_WIDTH / 2 - CENTER_LINE_WIDTH / 2;
  localparam int D1X  = SCREEN_WIDTH / 2 - 64;
  localparam int D2X  = SCREEN_WIDTH / 2 + 40;
  localparam int DY   = 16;
  localparam int PRST = (SCREEN_HEIGHT - PADDLE_HEIGHT) / 2;
  localparam int BXR  = (SCREEN_WIDTH - BALL_SIZE) / 2;
  localparam int BYR  = (SCREEN_HEIGHT - BALL_SIZE) / 2;

  logic [9:0] r_p1y, r_p2y, r_bx, r_by;
  logic [3:0] r_s1, r_s2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_p1y <= 10'(PRST);
      r_p2y <= 10'(PRST);
      r_bx  <= 10'(BXR);
      r_by  <= 10'(BYR);
      r_s1  <= 4'd0;
      r_s2  <= 4'd0;
    end else if (frame_start) begin
      r_p1y <= paddle1_y;
      r_p2y <= paddle2_y;
      r_bx  <= ball_x;
      r_by  <= ball_y;
      r_s1  <= score1;
      r_s2  <= score2;
    end
  end

  flash_st_t     r_fst  [2];
  logic [CW-1:0] r_fcnt [2];
  logic [1:0]    w_goal;
  logic [1:0]    w_show;

  assign w_goal = {goal_p2, goal_p1};

  // A goal reloads even when frame_start arrives in the same cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        r_fst[i]  <= FL_IDLE;
        r_fcnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_goal[i]) begin
          r_fst[i]  <= FL_FLASH;
          r_fcnt[i] <= CW'(FLASH_FRAMES);
        end else if (r_fst[i] == FL_FLASH && frame_start) begin
          r_fcnt[i] <= r_fcnt[i] - CW'(1);
          if (r_fcnt[i] == CW'(1)) r_fst[i] <= FL_IDLE;
        end
      end
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_show
    assign w_show[g] = (r_fst[g] == FL_IDLE) || r_fcnt[g][2];
  end

  logic [10:0] w_dx1, w_dx2, w_dy, w_c1, w_c2, w_row, w_ymod;

  assign w_dx1  = {1'b0, x} - 11'(D1X);
  assign w_dx2  = {1'b0, x} - 11'(D2X);
  assign w_dy   = {1'b0, y} - 11'(DY);
  assign w_c1   = w_dx1 / 11'(GLYPH_SCALE);
  assign w_c2   = w_dx2 / 11'(GLYPH_SCALE);
  assign w_row  = w_dy / 11'(GLYPH_SCALE);
  assign w_ymod = {1'b0, y} % 11'(DASH_PERIOD);

  logic       r1_valid, r1_p1, r1_p2, r1_ball, r1_line;
  logic       r1_in1, r1_in2;
  logic [1:0] r1_c1, r1_c2;
  logic [2:0] r1_row;
  logic [3:0] r1_d1, r1_d2;
  logic       w_ybox;

  assign w_ybox = in_span(y, 10'(DY), 11'(5 * GLYPH_SCALE));

  // A hidden flashing digit is sent down as the blank code 15.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r1_valid <= 1'b0;
      r1_p1    <= 1'b0;
      r1_p2    <= 1'b0;
      r1_ball  <= 1'b0;
      r1_line  <= 1'b0;
      r1_in1   <= 1'b0;
      r1_in2   <= 1'b0;
      r1_c1    <= 2'd0;
      r1_c2    <= 2'd0;
      r1_row   <= 3'd0;
      r1_d1    <= 4'd0;
      r1_d2    <= 4'd0;
    end else begin
      r1_valid <= pix_valid;
      r1_p1    <= in_span(x, 10'(PADDLE_INSET), 11'(PADDLE_WIDTH))
                  && in_span(y, r_p1y, 11'(PADDLE_HEIGHT));
      r1_p2    <= in_span(x, 10'(P2X), 11'(PADDLE_WIDTH))
                  && in_span(y, r_p2y, 11'(PADDLE_HEIGHT));
      r1_ball  <= in_span(x, r_bx, 11'(BALL_SIZE))
                  && in_span(y, r_by, 11'(BALL_SIZE));
      r1_line  <= in_span(x, 10'(LNX), 11'(CENTER_LINE_WIDTH))
                  && (w_ymod < 11'(DASH_PERIOD / 2));
      r1_in1   <= w_ybox
                  && in_span(x, 10'(D1X), 11'(3 * GLYPH_SCALE));
      r1_in2   <= w_ybox
                  && in_span(x, 10'(D2X), 11'(3 * GLYPH_SCALE));
      r1_c1    <= w_c1[1:0];
      r1_c2    <= w_c2[1:0];
      r1_row   <= w_row[2:0];
      r1_d1    <= w_show[0] ? r_s1 : 4'hF;
      r1_d2    <= w_show[1] ? r_s2 : 4'hF;
    end
  end

  logic w_g1, w_g2;

  score_glyph_rom u_glyph1 (
    .i_digit (r1_d1),
    .i_col   (r1_c1),
    .i_row   (r1_row),
    .o_pix   (w_g1)
  );

  score_glyph_rom u_glyph2 (
    .i_digit (r1_d2),
    .i_col   (r1_c2),
    .i_row   (r1_row),
    .o_pix   (w_g2)
  );

  rgb_t w_rgb;
  rgb_t r_rgb;
  logic r_ov;

  always_comb begin
    w_rgb = BLACK;
    if (!r1_valid)                                    w_rgb = BLACK;
    else if (r1_p1)                                   w_rgb = RED;
    else if (r1_p2)                                   w_rgb = GREEN;
    else if (r1_ball)                                 w_rgb = RED;
    else if ((r1_in1 && w_g1) || (r1_in2 && w_g2))    w_rgb = WHITE;
    else if (r1_line)                                 w_rgb = GREY;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rgb <= BLACK;
      r_ov  <= 1'b0;
    end else begin
      r_rgb <= w_rgb;
      r_ov  <= r1_valid;
    end
  end

  assign vga_red   = r_rgb.r;
  assign vga_green = r_rgb.g;
  assign vga_blue  = r_rgb.b;
  assign out_valid = r_ov;

endmodule
